// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing defaults and helpers for the timing generator
// and its region decoder.
package vga_pkg;

  localparam int CNT_W = 10;
  localparam int FC_W  = 8;
  localparam int DIV_W = 4;

  localparam int H_VIS_D  = 640;
  localparam int H_FP_D   = 16;
  localparam int H_SYNC_D = 96;
  localparam int H_BP_D   = 48;
  localparam int V_VIS_D  = 480;
  localparam int V_FP_D   = 10;
  localparam int V_SYNC_D = 2;
  localparam int V_BP_D   = 33;

  localparam int H_TOTAL = H_VIS_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int V_TOTAL = V_VIS_D + V_FP_D + V_SYNC_D + V_BP_D;

  // Half-open interval test [lo, hi) used by the region decoder.
  function automatic logic in_range(input int x, input int lo, input int hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running VGA timing generator: pixel-rate divider, h/v counters and
// registered sync/active/start strobes aligned with the counters.
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int H_VIS   = H_VIS_D,
  parameter int H_FP    = H_FP_D,
  parameter int H_SYNC  = H_SYNC_D,
  parameter int H_BP    = H_BP_D,
  parameter int V_VIS   = V_VIS_D,
  parameter int V_FP    = V_FP_D,
  parameter int V_SYNC  = V_SYNC_D,
  parameter int V_BP    = V_BP_D
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] h_readwire,
  output logic [CNT_W-1:0] v_readwire,
  output logic             pix_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic             line_start,
  output logic             frame_start,
  output logic [FC_W-1:0]  frame_count
);

  localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VT - 1);

  logic [DIV_W-1:0] div_q;
  logic             tick_nxt;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             hsync_nxt;
  logic             vsync_nxt;
  logic             active_nxt;
  logic             h_zero_nxt;
  logic             frame_zero_nxt;

  // The edge that wraps the divider is the edge that advances the pixel, so
  // pix_tick and the new counter values appear in the same clk.
  assign tick_nxt = (div_q == DIV_LAST);

  always_comb begin
    h_nxt = h_readwire;
    v_nxt = v_readwire;
    if (tick_nxt) begin
      if (h_readwire == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v_readwire == V_LAST) ? '0 : v_readwire + 1'b1;
      end else begin
        h_nxt = h_readwire + 1'b1;
      end
    end
  end

  // Region decode looks at the next counter values so the registered
  // strobes line up with the registered counters.
  always_comb begin
    hsync_nxt      = !in_range(int'(h_nxt), H_VIS + H_FP, H_VIS + H_FP + H_SYNC);
    vsync_nxt      = !in_range(int'(v_nxt), V_VIS + V_FP, V_VIS + V_FP + V_SYNC);
    active_nxt     = (int'(h_nxt) < H_VIS) && (int'(v_nxt) < V_VIS);
    h_zero_nxt     = tick_nxt && (h_nxt == '0);
    frame_zero_nxt = h_zero_nxt && (v_nxt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      pix_tick    <= 1'b0;
      h_readwire  <= '0;
      v_readwire  <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      active      <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      div_q       <= tick_nxt ? '0 : div_q + 1'b1;
      pix_tick    <= tick_nxt;
      h_readwire  <= h_nxt;
      v_readwire  <= v_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      active      <= active_nxt;
      line_start  <= h_zero_nxt;
      frame_start <= frame_zero_nxt;
      if (frame_zero_nxt) begin
        frame_count <= frame_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: a default 640x480 instance and a tiny
// CLK_DIV=1 instance, both with randomly timed asynchronous reset pulses.
module tb_vga_timing;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       tick;
    logic       hs;
    logic       vs;
    logic       act;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] ha, va, hb, vb;
  logic [7:0] fca, fcb;
  logic tka, hsa, vsa, aca, lsa, fsa;
  logic tkb, hsb, vsb, acb, lsb, fsb;

  vga_timing u_a (
    .clk(clk), .rst_n(rst_a_n), .h_readwire(ha), .v_readwire(va),
    .pix_tick(tka), .hsync(hsa), .vsync(vsa), .active(aca),
    .line_start(lsa), .frame_start(fsa), .frame_count(fca)
  );

  vga_timing #(
    .CLK_DIV(1), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_b (
    .clk(clk), .rst_n(rst_b_n), .h_readwire(hb), .v_readwire(vb),
    .pix_tick(tkb), .hsync(hsb), .vsync(vsb), .active(acb),
    .line_start(lsb), .frame_start(fsb), .frame_count(fcb)
  );

  exp_t act_a, act_b;
  assign act_a = '{ha, va, tka, hsa, vsa, aca, lsa, fsa, fca};
  assign act_b = '{hb, vb, tkb, hsb, vsb, acb, lsb, fsb, fcb};

  exp_t qa[$];
  exp_t qb[$];
  longint ta = 0;
  longint tb = 0;
  int total = 0;
  int bad = 0;
  event chk_ev;

  // Reference: t clks after reset release, the pixel index is t/CLK_DIV and
  // every other quantity follows from dividing that index by line/frame size.
  function automatic exp_t model(input longint t, input int cd,
                                 input int hv, input int hf, input int hsw, input int hbp,
                                 input int vv, input int vf, input int vsw, input int vbp);
    exp_t e;
    longint ht = hv + hf + hsw + hbp;
    longint vt = vv + vf + vsw + vbp;
    longint p = t / cd;
    longint h = p % ht;
    longint ln = p / ht;
    longint v = ln % vt;
    longint fr = ln / vt;
    logic tick = (t > 0) && ((t % cd) == 0);
    e.h    = 10'(h);
    e.v    = 10'(v);
    e.tick = tick;
    e.hs   = !((h >= hv + hf) && (h < hv + hf + hsw));
    e.vs   = !((v >= vv + vf) && (v < vv + vf + vsw));
    e.act  = (h < hv) && (v < vv);
    e.ls   = tick && (h == 0);
    e.fs   = tick && (h == 0) && (v == 0);
    e.fc   = 8'(fr % 256);
    return e;
  endfunction

  function automatic exp_t model_a(input longint t);
    return model(t, 4, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic exp_t model_b(input longint t);
    return model(t, 1, 8, 2, 3, 2, 6, 1, 2, 1);
  endfunction

  task automatic cmp(input int sel, input exp_t e);
    exp_t a;
    a = (sel == 0) ? act_a : act_b;
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL inst%0d t=%0t got h=%0d v=%0d tick=%b hs=%b vs=%b act=%b ls=%b fs=%b fc=%0d want h=%0d v=%0d tick=%b hs=%b vs=%b act=%b ls=%b fs=%b fc=%0d",
               sel, $time, a.h, a.v, a.tick, a.hs, a.vs, a.act, a.ls, a.fs, a.fc,
               e.h, e.v, e.tick, e.hs, e.vs, e.act, e.ls, e.fs, e.fc);
    end
  endtask

  // Stimulus side: one expected state per clk edge per instance.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_a_n) ta++;
      if (rst_b_n) tb++;
      qa.push_back(model_a(ta));
      qb.push_back(model_b(tb));
    end
  end

  // Monitor side: compare at the falling edge, or right after an async reset.
  initial begin
    forever begin
      @(negedge clk or chk_ev);
      while (qa.size() > 0) cmp(0, qa.pop_front());
      while (qb.size() > 0) cmp(1, qb.pop_front());
    end
  end

  task automatic pulse(input int sel, input int len);
    @(posedge clk);
    #2;
    if (sel == 0) begin
      rst_a_n = 1'b0;
      ta = 0;
      qa.delete();
    end else begin
      rst_b_n = 1'b0;
      tb = 0;
      qb.delete();
    end
    #1;
    if (sel == 0) qa.push_back(model_a(0));
    else          qb.push_back(model_b(0));
    ->chk_ev;
    repeat (len) @(posedge clk);
    #7;
    if (sel == 0) rst_a_n = 1'b1;
    else          rst_b_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #7;
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    fork
      begin
        repeat (8) begin
          repeat ($urandom_range(4000, 500)) @(posedge clk);
          pulse(0, $urandom_range(5, 1));
        end
      end
      begin
        repeat ($urandom_range(400, 50)) @(posedge clk);
        pulse(1, $urandom_range(4, 1));
        repeat (39000) @(posedge clk);
      end
    join
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning system clocks per pixel (100 MHz -> 25 MHz pixel rate); legal 1..16.
REQ-002 SHALL have parameters H_VIS/H_FP/H_SYNC/H_BP, defaults 640/16/96/48, meaning horizontal timing in pixels.
REQ-003 SHALL have parameters V_VIS/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, meaning vertical timing in lines.
REQ-004 SHALL have port clk, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-006 SHALL have port h_readwire, output, 10, meaning current pixel column 0..H_TOTAL-1, consumed by the region decoder.
REQ-007 SHALL have port v_readwire, output, 10, meaning current line 0..V_TOTAL-1.
REQ-008 SHALL have port pix_tick, output, 1, meaning a one-clk pulse on every pixel advance.
REQ-009 SHALL have port hsync, output, 1, meaning active-low horizontal sync.
REQ-010 SHALL have port vsync, output, 1, meaning active-low vertical sync.
REQ-011 SHALL have port active, output, 1, meaning the current (h,v) lies in the visible area.
REQ-012 SHALL have port line_start, output, 1, meaning a one-clk pulse when h_readwire becomes 0.
REQ-013 SHALL have port frame_start, output, 1, meaning a one-clk pulse when (h,v) becomes (0,0).
REQ-014 SHALL have port frame_count, output, 8, meaning completed frames, mod 256.

Function
REQ-015 SHALL define H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800) and V_TOTAL likewise (525).
REQ-016 SHALL use a divider counter 0..CLK_DIV-1; pix_tick SHALL assert for one clk when the divider equals CLK_DIV-1; with CLK_DIV=1, pix_tick SHALL be constantly 1 after reset.
REQ-017 SHALL update counters only on cycles where pix_tick=1; otherwise all outputs except pix_tick SHALL hold.
REQ-018 On tick: h_readwire SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and v_readwire SHALL increment, wrapping from V_TOTAL-1 to 0.
REQ-019 hsync, vsync, active, line_start and frame_start SHALL be registered outputs computed from the next counter values, so that they are coherent with h_readwire/v_readwire in the same clk, with zero skew.
REQ-020 hsync SHALL be 0 iff H_VIS+H_FP <= h < H_VIS+H_FP+H_SYNC (656..751).
REQ-021 vsync SHALL be 0 iff V_VIS+V_FP <= v < V_VIS+V_FP+V_SYNC (490..491).
REQ-022 active SHALL be 1 iff h < H_VIS and v < V_VIS.
REQ-023 line_start/frame_start SHALL assert only in the clk in which the counter transitions into 0 or (0,0), and SHALL be 0 in every other clk, including hold cycles.
REQ-024 frame_count SHALL increment, wrapping 255->0, in the same clk that frame_start asserts.
REQ-025 SHALL have no stall or back-pressure input; the timing is free-running.

Reset
REQ-026 While rst_n=0: divider=0, h_readwire=0, v_readwire=0, frame_count=0, hsync=1, vsync=1, active=1, pix_tick=0, line_start=0, frame_start=0.
REQ-027 A reset asserted mid-frame SHALL take effect immediately and asynchronously; after release, the first pix_tick SHALL occur CLK_DIV clks later and SHALL advance h to 1, with no frame_start pulse for the reset position.

Structure
REQ-028 Timing defaults and the derived H_TOTAL/V_TOTAL SHALL live in a shared package vga_pkg, which the region decoder also uses for its bounds.
REQ-029 SHALL be a single module with no sub-modules; the divider is inline.

Verification
REQ-030 Reset release with CLK_DIV=4 -> pix_tick at clks 4,8,12...; h=1 after the first tick, h=2 after the second; v=0.
REQ-031 h=799, v=10, tick -> h=0, v=11, line_start=1 for one clk, frame_start=0.
REQ-032 h=799, v=524, tick -> (0,0), frame_start=1, line_start=1, frame_count incremented; frame_count 255 -> 0.
REQ-033 Full-frame sweep -> hsync low for exactly 96 ticks per line starting at h=656; vsync low for exactly 2 lines starting at v=490; active count = 307200 per frame.
REQ-034 rst_n pulsed low at h=300, v=200 -> all outputs at reset values within the same clk, with no clk edge needed; normal counting resumes per REQ-027.
REQ-035 CLK_DIV=1 -> one pixel per clk; the frame period equals exactly 420000 clks.
